// File: rtl/ref_cache_req_arbiter.sv
// Round-robin arbiter sharing one reference cache between the IBC (port 0) and
// MC (port 1) requesters, with a tag FIFO steering responses back in issue order.
module ref_cache_req_arbiter #(
  parameter int unsigned COORD_W   = 14,
  parameter int unsigned DIM_W     = 7,
  parameter int unsigned REF_W     = 4,
  parameter int unsigned TAG_DEPTH = 4,
  localparam int unsigned PAY_W    = REF_W + 2*COORD_W + 2*DIM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [PAY_W-1:0] req_payload0,
  input  logic [PAY_W-1:0] req_payload1,
  input  logic [1:0]       rsp_ready,
  output logic [1:0]       rsp_valid,
  output logic             cache_valid_in,
  output logic [PAY_W-1:0] cache_payload,
  input  logic             cache_idle_out,
  output logic             cache_filer_idle,
  input  logic             cache_valid_out,
  input  logic             cache_full_idle,
  output logic             arb_idle,
  output logic             err_underflow
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {EMPTY = 1'b0, PEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               grant_q;
  logic               prio_q;
  logic               tag_q [TAG_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               fifo_full, fifo_empty;
  logic               grant_c, eligible, push, pop, head;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];

  // Tie goes to the requester holding the priority pointer
  always_comb begin
    grant_c = 1'b0;
    if (req_valid == 2'b10)      grant_c = 1'b1;
    else if (req_valid == 2'b11) grant_c = prio_q;
  end

  // Ready is gated by reset so nothing is accepted while reset is held
  assign eligible  = reset && (state_q == EMPTY) && (|req_valid) && !fifo_full;
  assign req_ready = eligible ? (grant_c ? 2'b10 : 2'b01) : 2'b00;

  assign push = (state_q == PEND) && cache_idle_out;
  assign pop  = cache_valid_out && !fifo_empty;

  assign cache_valid_in   = (state_q == PEND);
  assign cache_filer_idle = fifo_empty ? 1'b1 : rsp_ready[head];
  assign rsp_valid        = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign arb_idle         = (state_q == EMPTY) && fifo_empty && cache_full_idle;

  // Issue-slot next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (eligible) state_d = PEND;
      PEND:  if (cache_idle_out) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= EMPTY;
      grant_q       <= 1'b0;
      prio_q        <= 1'b0;
      cache_payload <= '0;
    end else begin
      state_q <= state_d;
      if (eligible) begin
        grant_q       <= grant_c;
        prio_q        <= ~grant_c;
        cache_payload <= grant_c ? req_payload1 : req_payload0;
      end
    end
  end

  // Tag FIFO recording the owner of each issued request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(TAG_DEPTH); i++) tag_q[i] <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= grant_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for a cache response with no outstanding owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             err_underflow <= 1'b0;
    else if (cache_valid_out && fifo_empty) err_underflow <= 1'b1;
  end

endmodule

// File: doc/ref_cache_req_arbiter.md
# ref_cache_req_arbiter

Shares one inter-prediction reference cache between two requesters: the IBC block-copy path (port 0) and the inter motion-compensation path (port 1). It round-robin arbitrates upstream requests into the cache's valid/idle handshake. It records the owner of every issued request in a tag FIFO and steers each cache output pulse back to the owning requester in issue order. It sits between the prediction front-ends and the cache upstream/downstream ports.

## Interface
- COORD_W, 14: signed start coordinate width (MVD_WIDTH - MV_L_FRAC_WIDTH_HIGH).
- DIM_W, 7: zero-based block width/height field width (LUMA_DIM_WDTH).
- REF_W, 4: reference index width (REF_ADDR_WDTH).
- TAG_DEPTH, 4: maximum outstanding requests at the cache; power of two, at least 2.
- PAY_W is derived, not overridable: REF_W+2*COORD_W+2*DIM_W. Payload is packed {ref_idx, start_y, start_x, height_y, width_x}, with width_x in the LSBs.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  2  per-requester request valid; bit0 is IBC, bit1 is MC.
- req_ready  out  2  per-requester accept; a request transfers when valid&ready are both 1 at a clock edge.
- req_payload0 / req_payload1  in  PAY_W each  request fields.
- rsp_ready  in  2  per-requester downstream ready (filter idle).
- rsp_valid  out  2  one-cycle response pulse to the owning requester.
- cache_valid_in  out  1  drives the cache's valid_in.
- cache_payload  out  PAY_W  registered payload to the cache.
- cache_idle_out  in  1  cache can accept a request.
- cache_filer_idle  out  1  drives the cache's filer_idle_in.
- cache_valid_out  in  1  cache output valid pulse.
- cache_full_idle  in  1  cache fully idle.
- arb_idle  out  1  arbiter and cache both quiescent.
- err_underflow  out  1  sticky: response arrived with no outstanding tag.

## Operation
- Two-state FSM for the issue slot: EMPTY and PEND.
- EMPTY:
  - Eligible when any req_valid=1 and outstanding < TAG_DEPTH.
  - Outstanding = tag FIFO count; the issue slot is empty in this state.
  - Grant: if one bit is valid, that requester wins. If both are valid, the requester not granted last wins. After reset, port 0 wins the first tie.
  - req_ready[grant] is asserted combinationally in the same cycle. The other requester's ready is 0.
  - On the edge: latch payload into cache_payload, update the last-grant pointer, go to PEND.
- PEND:
  - cache_valid_in=1; cache_payload is held stable.
  - req_ready=0 for both requesters.
  - Cache acceptance is the edge where cache_idle_out=1. On that edge, push the grant id into the tag FIFO and go to EMPTY.
- Response path:
  - Head of the tag FIFO selects the owner. cache_filer_idle = rsp_ready[head]; it is 1 when the FIFO is empty.
  - rsp_valid[head] = cache_valid_out when the FIFO is non-empty; the other rsp_valid bit is 0.
  - Each cache_valid_out cycle pops one tag.
- Simultaneous push (PEND accept) and pop: the count is unchanged and both take effect. A push into an empty FIFO is not visible at the head until the next cycle.
- cache_valid_out while the FIFO is empty: err_underflow is set (sticky until reset). No pop occurs and rsp_valid stays 0.
- arb_idle = EMPTY & FIFO empty & cache_full_idle.
- Reset asserted mid-operation flushes everything: FSM to EMPTY, FIFO cleared, pointer to port 0, err cleared. Any in-flight cache response after reset release counts as underflow. The top level resets the cache together with this block.

## Timing
- Reset values:
  - req_ready=0 while reset is held.
  - rsp_valid=0, cache_valid_in=0, cache_payload=0, err_underflow=0.
  - cache_filer_idle=1, arb_idle=cache_full_idle.
- Request to cache_valid_in: 1 cycle (requester accepted at edge N, cache_valid_in high after edge N).
- Maximum issue rate: one request per 2 cycles (EMPTY/PEND alternation).
- Response routing is combinational: 0 cycles from cache_valid_out to rsp_valid.
- With outstanding = TAG_DEPTH, req_ready stays 0 until a pop. A pop at edge N allows a grant in cycle N+1.

## Test plan
- Single IBC request: payload x=64, y=32, w=h=7, cache_idle_out=1.
  - Expect req_ready[0] in cycle 0 and cache_valid_in cycles 1..1.
  - A later cache_valid_out produces rsp_valid=2'b01. arb_idle returns to 1 once cache_full_idle=1.
- Both requesters valid continuously for 4 grants: grant order is 0,1,0,1. Responses in order give rsp_valid 01,10,01,10.
- Backpressure:
  - cache_idle_out=0 for 5 cycles: cache_valid_in and cache_payload are held, no req_ready.
  - Accept on the 6th cycle.
- FIFO full: TAG_DEPTH=4 requests issued with no responses.
  - The 5th request sees req_ready=0.
  - One cache_valid_out pulse, then the 5th request is granted the next cycle.
- Head steering and stray pulse:
  - Head=MC with rsp_ready[1]=0 and rsp_ready[0]=1: expect cache_filer_idle=0.
  - cache_valid_out with an empty FIFO: expect err_underflow=1, no rsp_valid.
- Reset (reset=0) asserted while in PEND with 2 tags outstanding: expect all outputs at reset values immediately (asynchronous), count 0 after release.
